// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller: FSM state encoding,
// SRAM strobe levels and a small width helper for counters.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } ctrl_state_t;

    // SRAM strobes are all active-low
    localparam logic STROBE_INACTIVE = 1'b1;
    localparam logic STROBE_ACTIVE   = 1'b0;

    // The SRAM data bus is always one 16-bit half-word wide
    localparam int HALF_WIDTH = 16;

    // Counter width that stays legal (>= 1 bit) even for a count of one
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/sram_burst_controller_if.sv
// Host-side request/response bundle of the SRAM burst controller.
// The host (master) raises a request and waits for ready; the controller
// (slave) returns the last read word.
interface sram_burst_controller_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  w_en_in;
    logic                  r_en_in;
    logic [31:0]           address_in;
    logic [DATA_WIDTH-1:0] write_data_in;
    logic [BYTES-1:0]      byte_en_in;
    logic [DATA_WIDTH-1:0] read_data_out;
    logic                  ready_out;

    modport master (
        output w_en_in, r_en_in, address_in, write_data_in, byte_en_in,
        input  read_data_out, ready_out
    );

    modport slave (
        input  w_en_in, r_en_in, address_in, write_data_in, byte_en_in,
        output read_data_out, ready_out
    );

endinterface

// File: rtl/sram_beat_timer.sv
// Wait-state and beat sequencing for one burst. While run is high the wait
// counter walks 0..WAIT_CYCLES-1 per beat and the beat counter advances at the
// end of each beat; both sit at zero whenever run is low.
module sram_beat_timer
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int BEATS       = 2,
    parameter int BEAT_W      = idx_width(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [BEAT_W-1:0] beat,
    output logic              last_cycle,
    output logic              last_beat
);

    localparam int WAIT_W = idx_width(WAIT_CYCLES);

    logic [WAIT_W-1:0] wait_cnt;

    assign last_cycle = run && (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
    assign last_beat  = (beat == BEAT_W'(BEATS - 1));

    // Advance the wait counter every cycle, roll to the next beat on the last wait cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (!run) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (last_cycle) begin
            wait_cnt <= '0;
            beat     <= last_beat ? '0 : beat + BEAT_W'(1);
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/sram_burst_controller.sv
// Splits one DATA_WIDTH host access into DATA_WIDTH/16 half-word beats on an
// asynchronous 16-bit SRAM, each beat lasting WAIT_CYCLES clocks.
module sram_burst_controller
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int WAIT_CYCLES     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_burst_controller_if.slave     host,
    inout  wire  [HALF_WIDTH-1:0]      sram_dq_out,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_out,
    output logic                       sram_ub_n_out,
    output logic                       sram_lb_n_out,
    output logic                       sram_we_n_out,
    output logic                       sram_ce_n_out,
    output logic                       sram_oe_n_out
);

    localparam int BEATS  = DATA_WIDTH / HALF_WIDTH;
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BEAT_W = idx_width(BEATS);

    ctrl_state_t state;
    ctrl_state_t state_next;

    logic                       request;
    logic                       in_access;
    logic                       is_write;
    logic [SRAM_ADDR_WIDTH-1:0] base_addr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [BYTES-1:0]           byte_en;
    logic [DATA_WIDTH-1:0]      rdata;
    logic [BEAT_W-1:0]          beat;
    logic                       last_cycle;
    logic                       last_beat;
    logic                       ready;
    logic                       dq_en;
    logic [HALF_WIDTH-1:0]      dq_drive;
    logic [HALF_WIDTH-1:0]      beat_word;
    logic [1:0]                 beat_bytes;

    assign request   = host.w_en_in | host.r_en_in;
    assign in_access = (state == ACCESS);

    sram_beat_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .BEATS       (BEATS),
        .BEAT_W      (BEAT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (in_access),
        .beat       (beat),
        .last_cycle (last_cycle),
        .last_beat  (last_beat)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept any request, finish after the last cycle of the last beat
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (request) state_next = ACCESS;
            ACCESS:  if (last_cycle && last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the whole request on acceptance so the host may change its inputs;
    // a simultaneous read and write is treated as a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_write  <= 1'b0;
            base_addr <= '0;
            wdata     <= '0;
            byte_en   <= '0;
        end else if (state == IDLE && request) begin
            is_write  <= host.w_en_in;
            base_addr <= SRAM_ADDR_WIDTH'((host.address_in / 32'(BYTES)) * 32'(BEATS));
            wdata     <= host.write_data_in;
            byte_en   <= host.byte_en_in;
        end
    end

    // Read beats land in their half of the read word at the end of the beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (in_access && !is_write && last_cycle) begin
            rdata[HALF_WIDTH*int'(beat) +: HALF_WIDTH] <= sram_dq_out;
        end
    end

    // SRAM strobes, address and bus drive decoded from state and the current beat
    always_comb begin
        sram_ce_n_out = STROBE_INACTIVE;
        sram_we_n_out = STROBE_INACTIVE;
        sram_oe_n_out = STROBE_INACTIVE;
        sram_ub_n_out = STROBE_INACTIVE;
        sram_lb_n_out = STROBE_INACTIVE;
        sram_addr_out = '0;
        dq_en         = 1'b0;
        dq_drive      = '0;
        ready         = 1'b0;
        beat_word     = wdata[HALF_WIDTH*int'(beat) +: HALF_WIDTH];
        beat_bytes    = byte_en[2*int'(beat) +: 2];
        unique case (state)
            IDLE: begin
                ready = !request;
            end
            ACCESS: begin
                sram_ce_n_out = STROBE_ACTIVE;
                sram_addr_out = base_addr + SRAM_ADDR_WIDTH'(beat);
                if (is_write) begin
                    // WE rises in the final cycle so the SRAM latches stable data
                    sram_we_n_out = last_cycle ? STROBE_INACTIVE : STROBE_ACTIVE;
                    sram_ub_n_out = ~beat_bytes[1];
                    sram_lb_n_out = ~beat_bytes[0];
                    dq_en         = 1'b1;
                    dq_drive      = beat_word;
                end else begin
                    sram_oe_n_out = STROBE_ACTIVE;
                    sram_ub_n_out = STROBE_ACTIVE;
                    sram_lb_n_out = STROBE_ACTIVE;
                end
            end
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign sram_dq_out        = dq_en ? dq_drive : {HALF_WIDTH{1'bz}};
    assign host.read_data_out = rdata;
    assign host.ready_out     = ready;

endmodule

// File: doc/sram_burst_controller.md
SRAM_BURST_CONTROLLER -- requirements
Module: sram_burst_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32: host word width; SHALL be a multiple of 16, range 16..128.
REQ-002 Parameter SRAM_ADDR_WIDTH, default 18: SRAM half-word address width.
REQ-003 Parameter WAIT_CYCLES, default 3: clock cycles per 16-bit SRAM beat; SHALL be >= 2.
REQ-004 Derived BEATS = DATA_WIDTH/16; BYTES = DATA_WIDTH/8.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 w_en_in  in  1  write request.
REQ-008 r_en_in  in  1  read request.
REQ-009 address_in  in  32  host byte address.
REQ-010 write_data_in  in  DATA_WIDTH  write word.
REQ-011 byte_en_in  in  BYTES  per-byte write enable, bit i covers bits [8i+7:8i].
REQ-012 read_data_out  out  DATA_WIDTH  last completed read word.
REQ-013 ready_out  out  1  request complete / controller free.
REQ-014 sram_dq_out  inout  16  SRAM data bus.
REQ-015 sram_addr_out  out  SRAM_ADDR_WIDTH  SRAM half-word address.
REQ-016 sram_ub_n_out, sram_lb_n_out, sram_we_n_out, sram_ce_n_out, sram_oe_n_out  out  1 each  active-low SRAM strobes.

Function
REQ-017 States IDLE, ACCESS, DONE; IDLE->ACCESS on edge with w_en_in or r_en_in high; ACCESS->DONE after last cycle of last beat; DONE->IDLE unconditionally.
REQ-018 On acceptance, address, write data, byte enables and op type SHALL be latched; later input changes SHALL NOT affect the transaction.
REQ-019 w_en_in and r_en_in both high SHALL be accepted as a write.
REQ-020 Base half-word address = (address_in / BYTES) * BEATS, truncated to SRAM_ADDR_WIDTH (wraps modulo 2^SRAM_ADDR_WIDTH); address bits below log2(BYTES) ignored.
REQ-021 Beat k (0..BEATS-1) SHALL drive sram_addr_out = base + k (modulo wrap) and carry word bits [16k+15:16k] (beat 0 = low half).
REQ-022 Each beat SHALL last exactly WAIT_CYCLES cycles; address stable across the beat.
REQ-023 Write beat: sram_we_n_out low in all cycles except the last of the beat; sram_dq_out driven with beat data for the whole beat; ub_n/lb_n = inverse of byte_en bits 2k+1/2k.
REQ-024 Write beat with both byte enables zero SHALL still take WAIT_CYCLES cycles with ub_n=lb_n=1.
REQ-025 Read beat: sram_oe_n_out low, ub_n=lb_n=0, sram_dq_out high-Z; dq sampled on the edge ending the beat's last cycle into read_data_out half k.
REQ-026 sram_ce_n_out low only in ACCESS; sram_dq_out high-Z in every cycle not a write beat.
REQ-027 ready_out = 1 in DONE, and in IDLE while both enables low; 0 otherwise.
REQ-028 Latency: accepting edge to ready_out high = BEATS*WAIT_CYCLES cycles; ready high exactly one cycle in DONE.
REQ-029 Request still held in IDLE after DONE SHALL start a new transaction.
REQ-030 read_data_out SHALL hold its value until the next read's beats overwrite it; writes never modify it.

Reset
REQ-031 rst high SHALL, asynchronously, force IDLE, counters 0, read_data_out 0, sram_addr_out 0, all SRAM strobes 1, sram_dq_out high-Z.
REQ-032 Reset mid-ACCESS SHALL abort the transaction with no further SRAM activity; ready_out follows REQ-027 from IDLE.

Structure
REQ-033 Package sram_ctrl_pkg SHALL hold the state encoding and SRAM strobe-inactive constants.
REQ-034 One sub-module sram_beat_timer SHALL hold the wait counter and beat counter, emitting last_cycle and last_beat.

Verification (DATA_WIDTH=32, WAIT_CYCLES=3, sram_model attached)
REQ-035 Write 0x3344_1122 at 0x0, byte_en 4'hF -> sram[0]=0x1122, sram[1]=0x3344; ready after 6 cycles.
REQ-036 Read at 0x0 after REQ-035 -> read_data_out=0x3344_1122 on ready.
REQ-037 Write 0xAABB_CCDD at 0x8, byte_en 4'b0101 -> sram[4] low byte 0xDD, sram[5] low byte 0xBB, upper bytes unchanged.
REQ-038 Both enables high, address 0x4 -> write performed, sram_oe_n_out stays 1.
REQ-039 rst pulse during beat 1 of a write -> strobes 1, dq high-Z immediately; sram[3] unchanged.
REQ-040 DATA_WIDTH=64 write 0x0011_2233_4455_6677 at 0x8 -> sram[4..7]=0x6677,0x4455,0x2233,0x0011; ready after 12 cycles.
